// File: rtl/srcnn_udiv_69ns_5ns_66_seq_if.sv
// Handshake bundle for the sequential unsigned divider.
// Both channels use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; the sender holds valid and its data
// steady until that edge, and the receiver may raise or lower ready freely.
interface srcnn_udiv_69ns_5ns_66_seq_if #(
  parameter int DIVIDEND_WIDTH = 69,
  parameter int DIVISOR_WIDTH  = 5,
  parameter int QUOTIENT_WIDTH = 66
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      out_valid;
  logic                      out_ready;
  logic [QUOTIENT_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      div_zero;
  logic                      q_ovf;

  // Requester side: supplies operands, consumes results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, q_ovf
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, q_ovf
  );
endinterface

// File: rtl/srcnn_udiv_69ns_5ns_66_seq.sv
// Sequential unsigned restoring divider: 69-bit dividend / 5-bit divisor,
// one quotient bit per cycle, MSB first. The 69-bit internal quotient is
// saturated to 66 bits with an overflow flag; the remainder is always exact.
// A zero divisor skips the iterations and reports div_zero.
module srcnn_udiv_69ns_5ns_66_seq #(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = 69,
  parameter int DIVISOR_WIDTH  = 5,
  parameter int QUOTIENT_WIDTH = 66
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  srcnn_udiv_69ns_5ns_66_seq_if.slave   bus,
  output logic [1:0]                    dbg_state
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  // Elaboration-time guard on the parameter set.
  if (QW > DW || QW < 1 || VW < 1 || ID < 0) begin : g_bad_params
    $error("srcnn_udiv: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   a_reg;   // latched dividend
  logic [VW-1:0]   b_reg;   // latched divisor
  logic [VW-1:0]   r_reg;   // partial remainder, always < divisor between steps
  logic [DW-1:0]   q_reg;   // full-width quotient under construction

  // One restoring step: the shifted remainder needs VW+1 bits for the compare.
  // After a successful subtract the result is below the divisor, so the low
  // VW bits of the difference are exact.
  logic [VW:0]     r_shift;
  logic            r_ge;
  logic [VW-1:0]   r_next;
  logic [DW-1:0]   q_next;
  logic [DW-1:0]   q_hi;
  logic            ovf_next;

  // Combinational datapath for the current iteration and the saturation test.
  always_comb begin
    r_shift  = {r_reg, a_reg[cnt]};
    r_ge     = (r_shift >= {1'b0, b_reg});
    r_next   = r_ge ? (r_shift[VW-1:0] - b_reg) : r_shift[VW-1:0];
    q_next   = q_reg;
    q_next[cnt] = r_ge;
    q_hi     = q_next >> QW;
    ovf_next = |q_hi;
  end

  assign dbg_state = state;

  // Control FSM with registered handshake and result outputs.
  // The zero-divisor path enters DONE with out_valid still low and raises it
  // one edge later; the CALC path raises it on its final iteration edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      r_reg         <= '0;
      q_reg         <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
      bus.q_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            a_reg        <= bus.dividend;
            b_reg        <= bus.divisor;
            if (bus.divisor != '0) begin
              state <= CALC;
              cnt   <= CW'(DW - 1);
              r_reg <= '0;
              q_reg <= '0;
            end else begin
              state         <= DONE;
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend[VW-1:0];
              bus.div_zero  <= 1'b1;
              bus.q_ovf     <= 1'b0;
            end
          end
        end
        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.quotient  <= ovf_next ? '1 : q_next[QW-1:0];
            bus.remainder <= r_next;
            bus.div_zero  <= 1'b0;
            bus.q_ovf     <= ovf_next;
          end
        end
        DONE: begin
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.div_zero  <= 1'b0;
            bus.q_ovf     <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srcnn_udiv_69ns_5ns_66_seq.sv
// Directed bench for the 69/5 sequential divider: latency, saturation,
// divide-by-zero, output back-pressure and mid-operation reset.
module tb_srcnn_udiv_69ns_5ns_66_seq;

  logic       ap_clk;
  logic       ap_rst_n;
  logic [1:0] dbg_state;

  int total;
  int bad;

  srcnn_udiv_69ns_5ns_66_seq_if bus ();

  srcnn_udiv_69ns_5ns_66_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one operation and check the result it produces.
  task automatic run_op(input string tag, input logic [68:0] a, input logic [4:0] b,
                        input logic [65:0] eq, input logic [4:0] er,
                        input logic edz, input logic eovf, input int elat, input int hold);
    int n;
    int lat;
    logic [65:0] sq;
    logic [4:0]  sr;
    logic        sdz, sovf;
    logic        unstable, rdy_seen;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check({tag, " ready"}, 128'(bus.in_ready), 128'd1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 69'($urandom());
    bus.divisor  = 5'($urandom_range(0, 31));
    check({tag, " state"}, 128'(dbg_state), (b != 0) ? 128'd1 : 128'd2);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(elat));
    check({tag, " quotient"}, 128'(bus.quotient), 128'(eq));
    check({tag, " remainder"}, 128'(bus.remainder), 128'(er));
    check({tag, " div_zero"}, 128'(bus.div_zero), 128'(edz));
    check({tag, " q_ovf"}, 128'(bus.q_ovf), 128'(eovf));
    if (hold > 0) begin
      sq = bus.quotient; sr = bus.remainder; sdz = bus.div_zero; sovf = bus.q_ovf;
      unstable = 1'b0; rdy_seen = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge ap_clk); #1;
        if (!bus.out_valid || bus.quotient !== sq || bus.remainder !== sr ||
            bus.div_zero !== sdz || bus.q_ovf !== sovf) unstable = 1'b1;
        if (bus.in_ready) rdy_seen = 1'b1;
      end
      check({tag, " hold stable"}, 128'(unstable), 128'd0);
      check({tag, " hold in_ready"}, 128'(rdy_seen), 128'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge ap_clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " post out_valid"}, 128'(bus.out_valid), 128'd0);
    check({tag, " post flags"}, 128'({bus.div_zero, bus.q_ovf, bus.quotient, bus.remainder}), 128'd0);
    check({tag, " post in_ready"}, 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    logic seen;
    total = 0;
    bad   = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    ap_rst_n      = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("reset in_ready", 128'(bus.in_ready), 128'd0);
    check("reset out_valid", 128'(bus.out_valid), 128'd0);
    check("reset outputs", 128'({bus.div_zero, bus.q_ovf, bus.quotient, bus.remainder}), 128'd0);
    check("reset state", 128'(dbg_state), 128'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("release in_ready", 128'(bus.in_ready), 128'd1);

    // 100 / 7 = 14 r 2
    run_op("t1", 69'd100, 5'd7, 66'd14, 5'd2, 1'b0, 1'b0, 69, 0);
    // (2^69-1) / 31: 2^69 = 16 mod 31, so remainder 15
    run_op("t2", {69{1'b1}}, 5'd31, 66'd19041800334151795216, 5'd15, 1'b0, 1'b0, 69, 0);
    // 2^68 / 1 saturates
    run_op("t3", {1'b1, 68'd0}, 5'd1, {66{1'b1}}, 5'd0, 1'b0, 1'b1, 69, 0);
    // largest quotient that fits: 2^66-1
    run_op("fit_max", {3'b000, {66{1'b1}}}, 5'd1, {66{1'b1}}, 5'd0, 1'b0, 1'b0, 69, 0);
    // 2^66 / 1 is the first value that overflows
    run_op("ovf_min", {3'b001, 66'd0}, 5'd1, {66{1'b1}}, 5'd0, 1'b0, 1'b1, 69, 0);
    // 2^66 / 2 = 2^65 fits
    run_op("half", {3'b001, 66'd0}, 5'd2, {1'b1, 65'd0}, 5'd0, 1'b0, 1'b0, 69, 0);
    run_op("eq", 69'd31, 5'd31, 66'd1, 5'd0, 1'b0, 1'b0, 69, 0);
    run_op("small", 69'd5, 5'd31, 66'd0, 5'd5, 1'b0, 1'b0, 69, 0);
    run_op("mid", 69'd1000, 5'd13, 66'd76, 5'd12, 1'b0, 1'b0, 69, 0);
    // divide by zero: remainder is low 5 bits of 0x1F3
    run_op("t4", 69'h1F3, 5'd0, {66{1'b1}}, 5'h13, 1'b1, 1'b0, 1, 0);
    // back-pressure for 10 cycles
    run_op("t5", 69'd100, 5'd7, 66'd14, 5'd2, 1'b0, 1'b0, 69, 10);

    // Reset during CALC aborts the operation.
    bus.dividend = 69'd100;
    bus.divisor  = 5'd7;
    bus.in_valid = 1'b1;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    repeat (30) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("t6 rst out_valid", 128'(bus.out_valid), 128'd0);
    check("t6 rst in_ready", 128'(bus.in_ready), 128'd0);
    check("t6 rst state", 128'(dbg_state), 128'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge ap_clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("t6 no result", 128'(seen), 128'd0);
    check("t6 in_ready", 128'(bus.in_ready), 128'd1);
    run_op("t6 fresh", 69'd100, 5'd7, 66'd14, 5'd2, 1'b0, 1'b0, 69, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
